// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the multi-channel PWM generator:
//   - channel function (mode) codes as driven on cfg_func
//   - timebase FSM state type
// The per-channel config struct depends on WIDTH, so it is declared inside
// pwm_multi_gen where WIDTH is known.
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam logic [1:0] FUNC_ALIGN_LEFT  = 2'b00;
  localparam logic [1:0] FUNC_ALIGN_RIGHT = 2'b01;
  localparam logic [1:0] FUNC_RANGE       = 2'b10;
  localparam logic [1:0] FUNC_OFF         = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/pwm_channel_cmp.sv
// -----------------------------------------------------------------------------
// pwm_channel_cmp
// Combinational mode compare for one PWM channel. Produces the raw (pre-
// polarity) level for the current timebase count. All compares unsigned.
// Ports:
//   i_func   channel mode (ALIGN_LEFT / ALIGN_RIGHT / RANGE / OFF)
//   i_cmp1   compare value 1
//   i_cmp2   compare value 2 (RANGE mode only)
//   i_period active period (ALIGN_RIGHT upper bound)
//   i_cnt    current timebase count
//   o_raw    raw channel level
// -----------------------------------------------------------------------------
module pwm_channel_cmp
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0]       i_func,
  input  logic [WIDTH-1:0] i_cmp1,
  input  logic [WIDTH-1:0] i_cmp2,
  input  logic [WIDTH-1:0] i_period,
  input  logic [WIDTH-1:0] i_cnt,
  output logic             o_raw
);

  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;

  always_comb begin
    // RANGE accepts the two compares in either order
    w_lo  = (i_cmp1 < i_cmp2) ? i_cmp1 : i_cmp2;
    w_hi  = (i_cmp1 < i_cmp2) ? i_cmp2 : i_cmp1;
    o_raw = 1'b0;
    case (i_func)
      FUNC_ALIGN_LEFT:  o_raw = (i_cmp1 != '0) && (i_cnt <= i_cmp1);
      FUNC_ALIGN_RIGHT: o_raw = (i_cnt >= i_cmp1) && (i_cnt <= i_period);
      FUNC_RANGE:       o_raw = (w_lo != w_hi) && (i_cnt >= w_lo) && (i_cnt < w_hi);
      FUNC_OFF:         o_raw = 1'b0;
      default:          o_raw = 1'b0;
    endcase
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// -----------------------------------------------------------------------------
// pwm_multi_gen
// Multi-channel PWM generator with a prescaled timebase. Period and per-channel
// config are double-buffered: writes land in shadow registers and are copied
// to the active set only at a period wrap (or continuously while idle).
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   en             global enable (low holds timebase idle)
//   prescale       counter advances every prescale+1 clocks
//   period_wr      shadow period write strobe, data in period_wdata
//   cfg_we         channel config write strobe; cfg_ch selects channel
//   cfg_func/cmp1/cmp2/pol  channel config write data
//   counter_val    current timebase count
//   period_end     one-clock pulse when the counter wraps to 0
//   cfg_pending    shadow holds data not yet loaded into active
//   pwm_out        registered PWM outputs, one per channel
// -----------------------------------------------------------------------------
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           en,
  input  logic [PRESCALE_W-1:0]                          prescale,
  input  logic                                           period_wr,
  input  logic [WIDTH-1:0]                               period_wdata,
  input  logic                                           cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                     cfg_func,
  input  logic [WIDTH-1:0]                               cfg_cmp1,
  input  logic [WIDTH-1:0]                               cfg_cmp2,
  input  logic                                           cfg_pol,
  output logic [WIDTH-1:0]                               counter_val,
  output logic                                           period_end,
  output logic                                           cfg_pending,
  output logic [CHANNELS-1:0]                            pwm_out
);

  typedef struct packed {
    logic [1:0]       func;
    logic [WIDTH-1:0] cmp1;
    logic [WIDTH-1:0] cmp2;
    logic             pol;
  } ch_cfg_t;

  pwm_state_e            r_state;
  logic [PRESCALE_W-1:0] r_presc;
  logic [WIDTH-1:0]      r_counter;
  logic                  r_period_end;
  logic                  r_pending;
  logic [WIDTH-1:0]      r_sh_period;
  logic [WIDTH-1:0]      r_act_period;
  ch_cfg_t               r_sh_cfg  [CHANNELS];
  ch_cfg_t               r_act_cfg [CHANNELS];
  logic [CHANNELS-1:0]   r_pwm;

  ch_cfg_t               w_new_cfg;
  logic                  w_cfg_hit;
  logic                  w_any_wr;
  logic                  w_tick;
  logic                  w_wrap;
  logic [CHANNELS-1:0]   w_raw;

  always_comb begin
    w_new_cfg.func = cfg_func;
    w_new_cfg.cmp1 = cfg_cmp1;
    w_new_cfg.cmp2 = cfg_cmp2;
    w_new_cfg.pol  = cfg_pol;
  end

  assign w_cfg_hit = cfg_we && (32'(cfg_ch) < CHANNELS);
  assign w_any_wr  = period_wr || w_cfg_hit;
  assign w_tick    = (r_presc == prescale);
  // >= so that a period shrunk below the running count (or period 0) still wraps
  assign w_wrap    = w_tick && (r_counter >= r_act_period);

  // Shadow registers: written from the config interface in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_period <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_sh_cfg[i] <= '0;
      end
    end else begin
      if (period_wr) r_sh_period <= period_wdata;
      if (w_cfg_hit) r_sh_cfg[cfg_ch] <= w_new_cfg;
    end
  end

  // Timebase FSM with active-register loading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_presc      <= '0;
      r_counter    <= '0;
      r_period_end <= 1'b0;
      r_pending    <= 1'b0;
      r_act_period <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_act_cfg[i] <= '0;
      end
    end else begin
      r_period_end <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_presc      <= '0;
          r_counter    <= '0;
          r_act_period <= r_sh_period;
          r_act_cfg    <= r_sh_cfg;
          r_pending    <= 1'b0;
          if (en) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!en) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_counter <= '0;
            r_pending <= r_pending | w_any_wr;
          end else if (w_tick) begin
            r_presc <= '0;
            if (w_wrap) begin
              r_counter    <= '0;
              r_period_end <= 1'b1;
              // active takes the pre-edge shadow; a same-cycle write stays pending
              r_act_period <= r_sh_period;
              r_act_cfg    <= r_sh_cfg;
              r_pending    <= w_any_wr;
            end else begin
              r_counter <= r_counter + 1'b1;
              r_pending <= r_pending | w_any_wr;
            end
          end else begin
            r_presc   <= r_presc + 1'b1;
            r_pending <= r_pending | w_any_wr;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    pwm_channel_cmp #(
      .WIDTH (WIDTH)
    ) u_cmp (
      .i_func   (r_act_cfg[g].func),
      .i_cmp1   (r_act_cfg[g].cmp1),
      .i_cmp2   (r_act_cfg[g].cmp2),
      .i_period (r_act_period),
      .i_cnt    (r_counter),
      .o_raw    (w_raw[g])
    );
  end

  // Outputs lag counter_val by one clock; idle forces raw low so pins sit at pol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_pwm[i] <= ((r_state == ST_RUN) && w_raw[i]) ^ r_act_cfg[i].pol;
      end
    end
  end

  assign counter_val = r_counter;
  assign period_end  = r_period_end;
  assign cfg_pending = r_pending;
  assign pwm_out     = r_pwm;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_gen
// Directed plus randomized stimulus for pwm_multi_gen (WIDTH=8, CHANNELS=4,
// PRESCALE_W=8). A behavioural model advanced on every clock edge predicts
// counter_val, period_end, cfg_pending and pwm_out.
// -----------------------------------------------------------------------------
module tb_pwm_multi_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] prescale;
  logic       period_wr;
  logic [7:0] period_wdata;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_func;
  logic [7:0] cfg_cmp1;
  logic [7:0] cfg_cmp2;
  logic       cfg_pol;
  logic [7:0] counter_val;
  logic       period_end;
  logic       cfg_pending;
  logic [3:0] pwm_out;

  int checks   = 0;
  int failures = 0;

  pwm_multi_gen #(
    .WIDTH      (8),
    .CHANNELS   (4),
    .PRESCALE_W (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .prescale     (prescale),
    .period_wr    (period_wr),
    .period_wdata (period_wdata),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_func     (cfg_func),
    .cfg_cmp1     (cfg_cmp1),
    .cfg_cmp2     (cfg_cmp2),
    .cfg_pol      (cfg_pol),
    .counter_val  (counter_val),
    .period_end   (period_end),
    .cfg_pending  (cfg_pending),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_run;
  int m_div, m_cnt;
  bit m_pe, m_pend;
  bit [3:0] m_out;
  int sh_per, act_per;
  int sh_f[4], sh_a[4], sh_b[4];
  bit sh_p[4];
  int act_f[4], act_a[4], act_b[4];
  bit act_p[4];

  int win_hi[4];
  int win_pe;

  function automatic bit ref_level(int f, int a, int b, int per, int cnt);
    int lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    case (f)
      0:       return (a != 0) && (cnt <= a);
      1:       return (cnt >= a) && (cnt <= per);
      2:       return (lo != hi) && (cnt >= lo) && (cnt < hi);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_div = 0; m_cnt = 0; m_pe = 0; m_pend = 0; m_out = '0;
    sh_per = 0; act_per = 0;
    for (int c = 0; c < 4; c++) begin
      sh_f[c] = 0; sh_a[c] = 0; sh_b[c] = 0; sh_p[c] = 0;
      act_f[c] = 0; act_a[c] = 0; act_b[c] = 0; act_p[c] = 0;
    end
  endtask

  task automatic load_active();
    act_per = sh_per;
    for (int c = 0; c < 4; c++) begin
      act_f[c] = sh_f[c]; act_a[c] = sh_a[c]; act_b[c] = sh_b[c]; act_p[c] = sh_p[c];
    end
  endtask

  // Advance the model across one clock edge using the inputs present at the edge.
  task automatic model_edge();
    bit [3:0] nout;
    bit wrote;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 4; c++)
      nout[c] = (m_run && ref_level(act_f[c], act_a[c], act_b[c], act_per, m_cnt)) ^ act_p[c];
    wrote = period_wr || cfg_we;
    m_pe = 0;
    if (!m_run) begin
      load_active();
      m_cnt = 0; m_div = 0; m_pend = 0;
      m_run = en;
    end else if (!en) begin
      m_run = 0; m_cnt = 0; m_div = 0;
      m_pend = m_pend | wrote;
    end else if (m_div != int'(prescale)) begin
      m_div = (m_div + 1) % 256;
      m_pend = m_pend | wrote;
    end else begin
      m_div = 0;
      if (m_cnt >= act_per) begin
        m_cnt = 0; m_pe = 1;
        load_active();
        m_pend = wrote;
      end else begin
        m_cnt = m_cnt + 1;
        m_pend = m_pend | wrote;
      end
    end
    if (period_wr) sh_per = int'(period_wdata);
    if (cfg_we) begin
      sh_f[cfg_ch] = int'(cfg_func);
      sh_a[cfg_ch] = int'(cfg_cmp1);
      sh_b[cfg_ch] = int'(cfg_cmp2);
      sh_p[cfg_ch] = cfg_pol;
    end
    m_out = nout;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".counter_val"}, 32'(counter_val), m_cnt);
    chk({tag, ".period_end"},  32'(period_end),  32'(m_pe));
    chk({tag, ".cfg_pending"}, 32'(cfg_pending), 32'(m_pend));
    chk({tag, ".pwm_out"},     32'(pwm_out),     32'(m_out));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic write_period(int d);
    period_wr = 1'b1; period_wdata = 8'(d);
    cyc();
    period_wr = 1'b0;
  endtask

  task automatic write_cfg(int ch, int f, int a, int b, bit p);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_func = 2'(f);
    cfg_cmp1 = 8'(a); cfg_cmp2 = 8'(b); cfg_pol = p;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic window(int n);
    for (int c = 0; c < 4; c++) win_hi[c] = 0;
    win_pe = 0;
    repeat (n) begin
      cyc();
      for (int c = 0; c < 4; c++) win_hi[c] += int'(pwm_out[c]);
      win_pe += int'(period_end);
    end
  endtask

  task automatic wait_cnt(int target, string tag);
    int n;
    n = 0;
    while (m_cnt != target && n < 64) begin
      cyc();
      n++;
    end
    chk(tag, 32'(counter_val), target);
  endtask

  task automatic wait_pe(string tag);
    int n;
    n = 0;
    while (!m_pe && n < 64) begin
      cyc();
      n++;
    end
    chk(tag, 32'(period_end), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int maxc;
    int n;
    rst = 1'b0; en = 1'b0; prescale = '0;
    period_wr = 1'b0; period_wdata = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_func = '0;
    cfg_cmp1 = '0; cfg_cmp2 = '0; cfg_pol = 1'b0;
    model_reset();

    // reset state
    #1 rst = 1'b1;
    #1;
    check_all("reset");
    chk("reset.pwm_zero", 32'(pwm_out), 0);
    cyc(); cyc();
    rst = 1'b0;

    // period 7, prescale 0; ch0 AL c1=3, ch1 RANGE 6/2, ch2 AL c1=0 pol=1, ch3 OFF
    write_period(7);
    write_cfg(0, 0, 3, 0, 1'b0);
    write_cfg(1, 2, 6, 2, 1'b0);
    write_cfg(2, 0, 0, 0, 1'b1);
    write_cfg(3, 3, 0, 0, 1'b0);
    cyc();
    en = 1'b1;
    repeat (16) cyc();
    window(8);
    chk("al_c3_high4", win_hi[0], 4);
    chk("range_62_high4", win_hi[1], 4);
    chk("al_c0_pol1_high", win_hi[2], 8);
    chk("off_low", win_hi[3], 0);
    window(24);
    chk("pe_every8", win_pe, 3);

    // RANGE with equal compares stays low
    write_cfg(1, 2, 4, 4, 1'b0);
    repeat (12) cyc();
    window(8);
    chk("range_eq_low", win_hi[1], 0);
    chk("al_c3_still4", win_hi[0], 4);

    // prescale 2, period 3, ch3 ALIGN_RIGHT c1=2
    en = 1'b0;
    cyc();
    chk("en_off_cnt0", 32'(counter_val), 0);
    prescale = 8'd2;
    write_period(3);
    write_cfg(3, 1, 2, 0, 1'b0);
    cyc();
    en = 1'b1;
    repeat (16) cyc();
    window(24);
    chk("presc_pe_every12", win_pe, 2);
    chk("ar_c2_high6_per12", win_hi[3], 12);
    chk("al_c3_gt_period_high", win_hi[0], 24);

    // shadow behaviour with prescale 0, period 7
    en = 1'b0;
    cyc();
    prescale = 8'd0;
    write_period(7);
    cyc();
    en = 1'b1;
    repeat (12) cyc();
    wait_cnt(2, "wait_cnt2");
    write_cfg(0, 0, 5, 0, 1'b0);
    chk("pending_after_write", 32'(cfg_pending), 1);
    wait_pe("wrap_after_write");
    chk("pending_clear_on_wrap", 32'(cfg_pending), 0);
    window(8);
    chk("al_c5_high6", win_hi[0], 6);
    wait_cnt(7, "wait_cnt7");
    write_cfg(0, 0, 1, 0, 1'b0);
    chk("wrap_write_pe", 32'(period_end), 1);
    chk("wrap_write_pending", 32'(cfg_pending), 1);
    window(8);
    chk("wrap_write_old_duty", win_hi[0], 6);
    window(8);
    chk("wrap_write_new_duty", win_hi[0], 2);

    // shrink period at cnt=5
    wait_cnt(5, "wait_cnt5");
    write_period(3);
    maxc = 0; n = 0;
    while (!m_pe && n < 64) begin
      cyc();
      if (int'(counter_val) > maxc) maxc = int'(counter_val);
      n++;
    end
    chk("shrink_finishes_to7", maxc, 7);
    chk("shrink_wrap_pe", 32'(period_end), 1);
    window(8);
    chk("shrink_pe_every4", win_pe, 2);

    // reset mid-period, with a pending shadow write that must be lost
    write_period(7);
    write_cfg(3, 0, 9, 0, 1'b1);
    wait_cnt(4, "wait_cnt4");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_cnt", 32'(counter_val), 0);
    chk("async_rst_pwm", 32'(pwm_out), 0);
    en = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_lost_shadow_pwm", 32'(pwm_out), 0);
    write_period(5);
    write_cfg(0, 0, 2, 0, 1'b0);
    write_cfg(1, 3, 0, 0, 1'b1);
    cyc();
    en = 1'b1;
    repeat (20) cyc();

    // en dropped mid-run
    wait_cnt(3, "wait_cnt3");
    en = 1'b0;
    cyc();
    chk("en_drop_cnt0", 32'(counter_val), 0);
    cyc(); cyc();
    chk("idle_pwm_is_pol", 32'(pwm_out), 32'h2);
    en = 1'b1;
    repeat (20) cyc();

    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      en           = ($urandom_range(0, 49) != 0);
      period_wr    = ($urandom_range(0, 19) == 0);
      period_wdata = 8'($urandom_range(0, 12));
      cfg_we       = ($urandom_range(0, 7) == 0);
      cfg_ch       = 2'($urandom_range(0, 3));
      cfg_func     = 2'($urandom_range(0, 3));
      cfg_cmp1     = 8'($urandom_range(0, 14));
      cfg_cmp2     = 8'($urandom_range(0, 14));
      cfg_pol      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) prescale = 8'($urandom_range(0, 2));
      cyc();
    end
    period_wr = 1'b0;
    cfg_we    = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
- Multi-channel PWM generator with its own prescaled timebase counter.
- Per-channel mode, compare and polarity registers are double-buffered: writes land in shadow registers and become active only at a period boundary, so duty-cycle changes never glitch.
- Sits between the config/register interface and the pad outputs; supersedes the single-channel combinational comparator used today.

Parameters:
- WIDTH, 8, counter, period and compare width in bits.
- CHANNELS, 4, number of independent PWM outputs (>=1).
- PRESCALE_W, 8, prescaler reload width in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; low holds the timebase in idle.
- prescale  in  PRESCALE_W  counter advances once every prescale+1 clk cycles; sampled continuously.
- period_wr  in  1  write strobe for shadow period.
- period_wdata  in  WIDTH  new period (counter runs 0..period).
- cfg_we  in  1  channel config write strobe.
- cfg_ch  in  max(1,$clog2(CHANNELS))  target channel; values >= CHANNELS are ignored.
- cfg_func  in  2  mode: 00 ALIGN_LEFT, 01 ALIGN_RIGHT, 10 RANGE_BETWEEN_COMPARES, 11 OFF.
- cfg_cmp1  in  WIDTH  compare1.
- cfg_cmp2  in  WIDTH  compare2.
- cfg_pol  in  1  1 inverts that channel's output.
- counter_val  out  WIDTH  current timebase count.
- period_end  out  1  one-clk pulse on the cycle the counter wraps to 0.
- cfg_pending  out  1  high while any shadow write has not yet been loaded.
- pwm_out  out  CHANNELS  registered PWM outputs.

Behaviour:
- Reset: all of the following clear to 0 — prescaler count, counter_val, period_end, cfg_pending, pwm_out, all shadow and active registers, and the FSM (IDLE).
- FSM, IDLE:
  - Counter and prescaler are held at 0.
  - Shadow is copied to active every cycle.
  - pwm_out = active pol per channel.
  - cfg_pending = 0.
  - en=1 -> RUN.
- FSM, RUN:
  - tick = (presc_cnt == prescale); on tick presc_cnt <= 0, otherwise presc_cnt + 1.
  - On tick with counter_val >= active_period: counter_val <= 0, period_end <= 1, and all shadows load into active.
  - On tick otherwise: counter_val + 1.
  - Using >= makes period=0 wrap on every tick.
  - en=0 -> IDLE on the next clk; counter_val clears that cycle.
- Shadow writes:
  - period_wr / cfg_we update the shadow registers on the clk edge and set cfg_pending.
  - A write on the same cycle as a wrap load is not bypassed: active takes the old shadow value, the new value applies at the next wrap, and cfg_pending stays 1.
  - Simultaneous period_wr and cfg_we are both accepted.
- Compare per channel (c1, c2, period are active values; cnt = counter_val):
  - ALIGN_LEFT: raw = (c1 != 0) && (cnt <= c1).
  - ALIGN_RIGHT: raw = (cnt >= c1) && (cnt <= period).
  - RANGE: lo = min(c1,c2), hi = max(c1,c2); raw = (lo != hi) && (lo <= cnt < hi).
  - OFF: raw = 0.
- Output: pwm_out[i] <= raw ^ pol, registered, so it is valid one clk after counter_val. All comparisons are unsigned, WIDTH bits.
- Compare values above period are legal, with no clamping (ALIGN_LEFT with c1 > period stays high for the whole period).
- Reset asserted mid-period returns to IDLE and zeros everything asynchronously; pending shadow writes are lost.

Decomposition:
- Package pwm_pkg:
  - localparams FUNC_ALIGN_LEFT=2'b00, FUNC_ALIGN_RIGHT=2'b01, FUNC_RANGE=2'b10, FUNC_OFF=2'b11.
  - FSM state encoding ST_IDLE/ST_RUN.
  - Packed struct type for channel config {func, cmp1, cmp2, pol}; width-generic via the WIDTH parameter at the use site.
- One sub-module, pwm_channel_cmp (parameter WIDTH): combinational mode compare per channel, instantiated CHANNELS times in a generate loop.
- Timebase, FSM and shadow/active registers stay in pwm_multi_gen.

Test Plan:
- Reset, then en=1, period=7, prescale=0, ch0 ALIGN_LEFT c1=3 -> counter 0..7 repeating; ch0 high 4 of 8 ticks; period_end pulses every 8 clk.
- ch1 RANGE c1=6, c2=2 -> high for cnt 2..5 (4 ticks); c1=c2=4 -> constantly low; ch2 ALIGN_LEFT c1=0, pol=1 -> constantly high.
- prescale=2, period=3 -> counter_val steps every 3 clk; period_end every 12 clk; ALIGN_RIGHT c1=2 -> high 6 clk per period.
- Write ch0 c1=5 mid-period at cnt=2 -> duty unchanged until the wrap; cfg_pending=1 until the period_end cycle, then 6/8 high; a write on the exact wrap cycle applies one period later.
- period_wr 7->3 at cnt=5 -> counter finishes to 7, then runs 0..3.
- Assert rst at cnt=4 and en=0 mid-run -> all outputs 0 immediately (rst) / counter 0 next clk (en) with pwm_out = pol; re-enable restarts from 0 with latest shadow config.
